// File: rtl/counter_datapath_fnd.sv
// rtl/counter_datapath_fnd.sv - Count-tick divider, 0-9999 up/down counter and 4-digit FND scan driver
//
// Purpose: divides clk into a count tick (only while enabled), runs a wrapping
// 0..9999 up/down counter with synchronous clear, and time-multiplexes the BCD
// digits of the count onto a common-anode 7-segment display.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous reset, active-low
//   enable    in   1   1 = counting runs, 0 = paused (tick phase held)
//   clear     in   1   synchronous clear of count and tick phase
//   mode      in   1   0 = count up, 1 = count down
//   count     out  14  current count, 0..9999
//   fnd_com   out  4   digit select, active-low, bit 0 = ones digit
//   fnd_data  out  8   segments {dp,g,f,e,d,c,b,a}, active-low

module counter_datapath_fnd #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic        mode,
  output logic [13:0] count,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [13:0]   COUNT_MAX = 14'd9999;

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    digit_sel;
  logic          tick;
  logic [13:0]   digit_val;
  logic [6:0]    seg;

  // A disabled cycle never ticks, so a pause landing on the last phase
  // leaves tick_cnt at TICK_MAX and the tick fires when enable returns.
  assign tick = enable && (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Clear outranks a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      if (mode) begin
        count <= (count == 14'd0) ? COUNT_MAX : count - 14'd1;
      end else begin
        count <= (count == COUNT_MAX) ? 14'd0 : count + 14'd1;
      end
    end
  end

  // Display scan runs free of enable and clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt  <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Only the selected digit is extracted; leading zeros are kept.
  always_comb begin
    digit_val = 14'd0;
    case (digit_sel)
      2'd0: digit_val = count % 14'd10;
      2'd1: digit_val = (count / 14'd10) % 14'd10;
      2'd2: digit_val = (count / 14'd100) % 14'd10;
      2'd3: digit_val = count / 14'd1000;
      default: digit_val = 14'd0;
    endcase
  end

  // {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    seg = 7'h7F;
    case (digit_val)
      14'd0: seg = 7'h40;
      14'd1: seg = 7'h79;
      14'd2: seg = 7'h24;
      14'd3: seg = 7'h30;
      14'd4: seg = 7'h19;
      14'd5: seg = 7'h12;
      14'd6: seg = 7'h02;
      14'd7: seg = 7'h78;
      14'd8: seg = 7'h00;
      14'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

  // The ones-digit decimal point lights to flag down-count mode.
  assign fnd_data = {~((digit_sel == 2'd0) && mode), seg};
  assign fnd_com  = ~(4'b0001 << digit_sel);

endmodule

// File: tb/tb_counter_datapath_fnd.sv
// tb/tb_counter_datapath_fnd.sv - Self-checking bench for counter_datapath_fnd against a behavioural model

module tb_counter_datapath_fnd;

  localparam int TD = 10;
  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        mode;
  logic [13:0] count;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  int checks   = 0;
  int failures = 0;

  int m_count;
  int m_phase;
  int m_scan;
  int m_dsel;

  logic [7:0] seg_tab [10];
  int pow10 [4];
  logic [7:0] pat_1234 [4];

  counter_datapath_fnd #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .SCAN_HZ(25)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clear   (clear),
    .mode    (mode),
    .count   (count),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_phase = 0;
    m_scan  = 0;
    m_dsel  = 0;
  endtask

  function automatic logic [7:0] exp_data();
    logic [7:0] d;
    d = seg_tab[(m_count / pow10[m_dsel]) % 10];
    if (m_dsel == 0 && mode) d = d & 8'h7F;
    return d;
  endfunction

  function automatic logic [3:0] exp_com();
    return 4'hF ^ (4'h1 << m_dsel);
  endfunction

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count));
    check("fnd_com", 32'(fnd_com), 32'(exp_com()));
    check("fnd_data", 32'(fnd_data), 32'(exp_data()));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (clear) begin
        m_count = 0;
        m_phase = 0;
      end else if (enable) begin
        m_phase = m_phase + 1;
        if (m_phase == TD) begin
          m_phase = 0;
          m_count = mode ? (m_count + 9999) % 10000 : (m_count + 1) % 10000;
        end
      end
      m_scan = m_scan + 1;
      if (m_scan == SD) begin
        m_scan = 0;
        m_dsel = (m_dsel + 1) % 4;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic run_until_count(input int target, input int budget);
    int n;
    n = 0;
    while (m_count != target && n < budget) begin
      step();
      n++;
    end
    check("reach_target", 32'(count), 32'(target));
  endtask

  initial begin
    int n;
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    pow10   = '{1, 10, 100, 1000};
    pat_1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    rst = 1'b0; enable = 1'b0; clear = 1'b0; mode = 1'b0;
    model_reset();

    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_com", 32'(fnd_com), 32'hE);
    check("rst_data", 32'(fnd_data), 32'hC0);
    mode = 1'b1;
    #1;
    check("rst_data_down", 32'(fnd_data), 32'h40);
    mode = 1'b0;
    step();
    step();

    // First ticks after release at 10, 20, 30 enabled cycles.
    rst = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i == 9)  check("pre_first_tick", 32'(count), 32'd0);
      if (i == 10) check("first_tick", 32'(count), 32'd1);
      if (i == 30) check("third_tick", 32'(count), 32'd3);
    end
    check("count_35", 32'(count), 32'd3);

    // Down wrap 0 -> 9999, then up wrap 9999 -> 0.
    clear = 1'b1; step(); clear = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < TD; i++) step();
    check("down_wrap", 32'(count), 32'd9999);
    enable = 1'b0;
    n = 0;
    while (m_dsel != 0 && n < 8) begin step(); n++; end
    check("dp_digit0_sel", 32'(fnd_com), 32'hE);
    check("dp_digit0_data", 32'(fnd_data), 32'h10);
    mode = 1'b0; enable = 1'b1;
    n = 0;
    while (count == 14'd9999 && n < 2 * TD) begin step(); n++; end
    check("up_wrap", 32'(count), 32'd0);

    // Pause after 5 enabled cycles: phase is kept.
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 5; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("pause_hold", 32'(count), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("resume_pre", 32'(count), 32'd0);
    step();
    check("resume_tick", 32'(count), 32'd1);

    // Clear coincident with a tick at count 42.
    run_until_count(42, 1000);
    n = 0;
    while (m_phase != TD - 1 && n < TD) begin step(); n++; end
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_over_tick", 32'(count), 32'd0);
    for (int i = 0; i < TD - 1; i++) step();
    check("after_clear_pre", 32'(count), 32'd0);
    step();
    check("after_clear_tick", 32'(count), 32'd1);

    // Async reset mid-scan at count 57.
    run_until_count(57, 1000);
    step();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(count), 32'd0);
    check("arst_com", 32'(fnd_com), 32'hE);
    check("arst_data", 32'(fnd_data), 32'hC0);
    step();
    rst = 1'b1;
    for (int i = 0; i < TD; i++) step();
    check("arst_resume", 32'(count), 32'd1);

    // Scan pattern at 1234.
    run_until_count(1234, 13000);
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("scan_1234_data", 32'(fnd_data), 32'(pat_1234[m_dsel]));
    end

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 8) != 0;
      clear  = ($urandom % 64) == 0;
      if (($urandom % 40) == 0) mode = ~mode;
      step();
    end
    clear = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
